// File: rtl/axi_pkg.sv
// Shared types for the AXI read arbiter: FSM states, master index and AXI response codes.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    typedef logic mst_idx_t;

    localparam mst_idx_t MST_M0 = 1'b0;
    localparam mst_idx_t MST_M1 = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rr_pick.sv
// Grant decision between the IFU (m0) and LSU (m1) read requests.
// Round-robin by default; ARB_FIXED_PRIO_EN makes m1 win every simultaneous request.
module axi_rr_pick
    import axi_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant
);

`ifdef ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_grant = MST_M0;
        if (i_req[1]) begin
            o_grant = MST_M1;
        end
    end
`else
    always_comb begin
        o_grant = MST_M0;
        if (i_req == 2'b11) begin
            o_grant = (i_last == MST_M0) ? MST_M1 : MST_M0;
        end else if (i_req[1]) begin
            o_grant = MST_M1;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arb.sv
// Two-master AXI read arbiter in front of a single memory slave; m1 write channels pass straight through.
// Build option: ARB_FIXED_PRIO_EN (m1 wins simultaneous read requests).
//
// state   | meaning
// ST_IDLE | no grant held; arbitrate pending read requests
// ST_ADDR | granted master's AR forwarded to the slave
// ST_DATA | slave R beats routed to the granted master and counted down
module axi_rd_arb
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
)
(
    input  logic                clock,
    input  logic                reset,

    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    output logic                m0_rlast,
    output logic [ID_W-1:0]     m0_rid,
    input  logic                m0_rready,

    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    output logic                m1_rlast,
    output logic [ID_W-1:0]     m1_rid,
    input  logic                m1_rready,

    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,

    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    input  logic                s_rlast,
    input  logic [ID_W-1:0]     s_rid,
    output logic                s_rready,

    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_granted_once;
    logic       r_wr_out;
    logic [7:0] r_beat_cnt;

    logic [1:0] w_req;
    logic       w_pick;
    logic       w_rr_last;
    logic       w_gnt_arvalid;
    logic       w_gnt_rready;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic       w_last_beat;
    logic       w_unused_rlast;

    // The slave's rlast is unreliable; the beat counter alone ends a burst.
    assign w_unused_rlast = s_rlast;

    assign w_req = {m1_arvalid & ~r_wr_out, m0_arvalid};

    // Until the first grant after reset, pretend m1 went last so m0 wins a tie.
    assign w_rr_last = r_granted_once ? r_last_grant : MST_M1;

    axi_rr_pick u_pick (
        .i_req   (w_req),
        .i_last  (w_rr_last),
        .o_grant (w_pick)
    );

    assign w_gnt_arvalid = (r_grant == MST_M1) ? m1_arvalid : m0_arvalid;
    assign w_gnt_rready  = (r_grant == MST_M1) ? m1_rready  : m0_rready;
    assign w_ar_hs       = s_arvalid & s_arready;
    assign w_r_hs        = s_rvalid & s_rready;
    assign w_last_beat   = (r_beat_cnt == 8'd0);

    assign s_arid    = (r_grant == MST_M1) ? m1_arid    : m0_arid;
    assign s_arlen   = (r_grant == MST_M1) ? m1_arlen   : m0_arlen;
    assign s_arsize  = (r_grant == MST_M1) ? m1_arsize  : m0_arsize;
    assign s_arburst = (r_grant == MST_M1) ? m1_arburst : m0_arburst;
    assign s_araddr  = (r_grant == MST_M1) ? m1_araddr  : m0_araddr;

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rid   = s_rid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!w_gnt_arvalid) begin
                    w_state_nxt = ST_IDLE;
                end else if (s_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_r_hs && w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rlast   = 1'b0;
        m1_rlast   = 1'b0;
        if (r_state == ST_ADDR) begin
            s_arvalid = w_gnt_arvalid;
            if (r_grant == MST_M1) begin
                m1_arready = s_arready;
            end else begin
                m0_arready = s_arready;
            end
        end
        if (r_state == ST_DATA) begin
            s_rready = w_gnt_rready;
            if (r_grant == MST_M1) begin
                m1_rvalid = s_rvalid;
                m1_rlast  = w_last_beat;
            end else begin
                m0_rvalid = s_rvalid;
                m0_rlast  = w_last_beat;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_grant        <= MST_M0;
            r_last_grant   <= MST_M0;
            r_granted_once <= 1'b0;
            r_beat_cnt     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_grant        <= w_pick;
                r_last_grant   <= w_pick;
                r_granted_once <= 1'b1;
            end
            if ((r_state == ST_ADDR) && w_ar_hs) begin
                r_beat_cnt <= s_arlen;
            end else if ((r_state == ST_DATA) && w_r_hs && !w_last_beat) begin
                r_beat_cnt <= r_beat_cnt - 8'd1;
            end
        end
    end

    // A new AW wins over a coincident B so the flag covers the newer write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_out <= 1'b0;
        end else if (s_awvalid && s_awready) begin
            r_wr_out <= 1'b1;
        end else if (s_bvalid && s_bready) begin
            r_wr_out <= 1'b0;
        end
    end

    assign s_awid     = m1_awid;
    assign s_awaddr   = m1_awaddr;
    assign s_awlen    = m1_awlen;
    assign s_awsize   = m1_awsize;
    assign s_awburst  = m1_awburst;
    assign s_awvalid  = m1_awvalid;
    assign m1_awready = s_awready;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wlast    = m1_wlast;
    assign s_wvalid   = m1_wvalid;
    assign m1_wready  = s_wready;
    assign m1_bid     = s_bid;
    assign m1_bresp   = s_bresp;
    assign m1_bvalid  = s_bvalid;
    assign s_bready   = m1_bready;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Scoreboard bench for axi_rd_arb: directed reads, arbitration order, write blocking, beat counting, reset abort.
module tb_axi_rd_arb;
    import axi_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [ID_W-1:0] m0_arid, m1_arid, m0_rid, m1_rid, m1_awid, m1_bid;
    logic [7:0] m0_arlen, m1_arlen, m1_awlen;
    logic [2:0] m0_arsize, m1_arsize, m1_awsize;
    logic [1:0] m0_arburst, m1_arburst, m1_awburst;
    logic [ADDR_W-1:0] m0_araddr, m1_araddr, m1_awaddr;
    logic m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, m1_wdata;
    logic [1:0] m0_rresp, m1_rresp, m1_bresp;
    logic m0_rvalid, m0_rlast, m0_rready, m1_rvalid, m1_rlast, m1_rready;
    logic m1_awvalid, m1_awready, m1_wlast, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [DATA_W/8-1:0] m1_wstrb, s_wstrb;

    logic [ID_W-1:0] s_arid, s_rid, s_awid, s_bid;
    logic [7:0] s_arlen, s_awlen;
    logic [2:0] s_arsize, s_awsize;
    logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [DATA_W-1:0] s_rdata, s_wdata;
    logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    axi_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m0_rid(m0_rid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
        .m1_rid(m1_rid), .m1_rready(m1_rready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
        .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
        .m1_bready(m1_bready),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready)
    );

    typedef struct {
        logic             mst;
        logic [ID_W-1:0]  id;
        logic [63:0]      data;
        logic             last;
    } exp_r_t;

    typedef struct {
        logic             mst;
        logic [ID_W-1:0]  id;
        logic [31:0]      addr;
        logic [7:0]       len;
    } exp_ar_t;

    exp_r_t      exp_r[$];
    exp_ar_t     exp_ar[$];
    logic [63:0] slv_data_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int slv_delay = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input logic mst, input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [63:0] base);
        exp_ar_t a;
        exp_r_t  r;
        a.mst = mst; a.id = id; a.addr = addr; a.len = len;
        exp_ar.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            r.mst  = mst;
            r.id   = id;
            r.data = base + 64'(i);
            r.last = (i == int'(len));
            exp_r.push_back(r);
            slv_data_q.push_back(base + 64'(i));
        end
    endtask

    task automatic ar_issue(input int m, input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        if (m == 0) begin
            m0_arid = id; m0_araddr = addr; m0_arlen = len; m0_arvalid = 1'b1;
        end else begin
            m1_arid = id; m1_araddr = addr; m1_arlen = len; m1_arvalid = 1'b1;
        end
        while (!rdy && n < 200) begin
            @(negedge clock);
            rdy = (m == 0) ? m0_arready : m1_arready;
            n++;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL ar_timeout_m%0d: got no arready expected arready within 200 cycles", m);
        end
        @(posedge clock); #1;
        if (m == 0) m0_arvalid = 1'b0;
        else        m1_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_r.size() != 0 || dut.r_state != ST_IDLE) && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_r.size());
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic mon_r(input logic m, input logic [ID_W-1:0] id, input logic [63:0] data,
                         input logic [1:0] resp, input logic last);
        exp_r_t e;
        if (exp_r.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL r_unexpected: got beat on m%0d data 0x%0h expected none", m, data);
        end else begin
            e = exp_r.pop_front();
            check("r_master", 64'(m), 64'(e.mst));
            check("r_id", 64'(id), 64'(e.id));
            check("r_data", data, e.data);
            check("r_resp", 64'(resp), 64'(RESP_OKAY));
            check("r_last", 64'(last), 64'(e.last));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes an AR or R handshake.
    initial begin : monitor
        exp_ar_t a;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (m0_rvalid || m1_rvalid)
                    check("r_exclusive", 64'(m0_rvalid & m1_rvalid), 64'd0);
                if (m0_rvalid && m0_rready) mon_r(1'b0, m0_rid, m0_rdata, m0_rresp, m0_rlast);
                if (m1_rvalid && m1_rready) mon_r(1'b1, m1_rid, m1_rdata, m1_rresp, m1_rlast);
                if (s_arvalid && s_arready) begin
                    if (exp_ar.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ar_unexpected: got araddr 0x%0h expected none", s_araddr);
                    end else begin
                        a = exp_ar.pop_front();
                        check("ar_id", 64'(s_arid), 64'(a.id));
                        check("ar_addr", 64'(s_araddr), 64'(a.addr));
                        check("ar_len", 64'(s_arlen), 64'(a.len));
                        check("ar_ready_route", 64'({m1_arready, m0_arready}),
                              (a.mst == MST_M1) ? 64'd2 : 64'd1);
                    end
                end
            end
        end
    end

    // Memory slave: answers each AR after slv_delay cycles, never drives rlast.
    initial begin : slave_model
        int              beats_left;
        int              dly;
        logic            ar_hs;
        logic            r_hs;
        logic [7:0]      cap_len;
        logic [ID_W-1:0] cap_id;
        beats_left = 0;
        dly = 0;
        cap_len = '0;
        cap_id = '0;
        s_rvalid = 1'b0;
        s_rdata = '0;
        s_rid = '0;
        forever begin
            @(negedge clock);
            ar_hs = s_arvalid & s_arready;
            r_hs  = s_rvalid & s_rready;
            if (ar_hs) begin
                cap_len = s_arlen;
                cap_id  = s_arid;
            end
            @(posedge clock); #1;
            if (!reset) begin
                beats_left = 0;
                dly = 0;
                s_rvalid = 1'b0;
                slv_data_q.delete();
                continue;
            end
            if (ar_hs) begin
                beats_left = int'(cap_len) + 1;
                dly = slv_delay;
                s_rid = cap_id;
            end
            if (r_hs) begin
                beats_left--;
                if (slv_data_q.size() > 0) void'(slv_data_q.pop_front());
            end
            if (dly > 0) dly--;
            s_rvalid = (beats_left > 0) && (dly == 0);
            s_rdata  = (slv_data_q.size() > 0) ? slv_data_q[0] : '0;
        end
    end

    initial begin : stimulus
        int   n;
        logic found;
        m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd3; m0_arburst = 2'b01; m0_araddr = '0;
        m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd3; m1_arburst = 2'b01; m1_araddr = '0;
        m1_arvalid = 1'b0; m1_rready = 1'b1;
        m1_awid = '0; m1_awaddr = '0; m1_awlen = '0; m1_awsize = 3'd3; m1_awburst = 2'b01;
        m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0; m1_wvalid = 1'b0;
        m1_bready = 1'b1;
        s_arready = 1'b1; s_rresp = RESP_OKAY; s_rlast = 1'b0;
        s_awready = 1'b1; s_wready = 1'b1; s_bid = '0; s_bresp = RESP_OKAY; s_bvalid = 1'b0;

        #12;
        check("rst_m0_arready", 64'(m0_arready), 64'd0);
        check("rst_m1_arready", 64'(m1_arready), 64'd0);
        check("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
        check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        check("rst_s_rready", 64'(s_rready), 64'd0);
        check("rst_beat_cnt", 64'(dut.r_beat_cnt), 64'd0);
        check("rst_wr_flag", 64'(dut.r_wr_out), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Single m0 read, slave answers after 5 cycles.
        slv_delay = 5;
        expect_rd(MST_M0, 4'h1, 32'h8000_0000, 8'd0, 64'h1234);
        ar_issue(0, 4'h1, 32'h8000_0000, 8'd0);
        wait_idle();

        // Two rounds of simultaneous requests from a fresh reset.
        reset_pulse();
        slv_delay = 1;
`ifdef ARB_FIXED_PRIO_EN
        expect_rd(MST_M1, 4'h9, 32'h8000_2000, 8'd1, 64'hB000);
        expect_rd(MST_M0, 4'h2, 32'h8000_1000, 8'd0, 64'hA000);
`else
        expect_rd(MST_M0, 4'h2, 32'h8000_1000, 8'd0, 64'hA000);
        expect_rd(MST_M1, 4'h9, 32'h8000_2000, 8'd1, 64'hB000);
`endif
        fork
            ar_issue(0, 4'h2, 32'h8000_1000, 8'd0);
            ar_issue(1, 4'h9, 32'h8000_2000, 8'd1);
        join
        wait_idle();
`ifdef ARB_FIXED_PRIO_EN
        expect_rd(MST_M1, 4'hA, 32'h8000_4000, 8'd2, 64'hD000);
        expect_rd(MST_M0, 4'h3, 32'h8000_3000, 8'd0, 64'hC000);
`else
        expect_rd(MST_M0, 4'h3, 32'h8000_3000, 8'd0, 64'hC000);
        expect_rd(MST_M1, 4'hA, 32'h8000_4000, 8'd2, 64'hD000);
`endif
        fork
            ar_issue(0, 4'h3, 32'h8000_3000, 8'd0);
            ar_issue(1, 4'hA, 32'h8000_4000, 8'd2);
        join
        wait_idle();

        // Outstanding m1 write blocks m1 reads but not m0 reads.
        m1_awid = 4'h2; m1_awaddr = 32'h8000_0010; m1_awlen = 8'd0; m1_awvalid = 1'b1;
        m1_wdata = 64'hDEAD_BEEF_0000_0001; m1_wstrb = 8'hFF; m1_wlast = 1'b1; m1_wvalid = 1'b1;
        @(negedge clock);
        check("aw_pass_addr", 64'(s_awaddr), 64'h8000_0010);
        check("aw_pass_valid", 64'(s_awvalid), 64'd1);
        check("w_pass_data", s_wdata, 64'hDEAD_BEEF_0000_0001);
        @(posedge clock); #1;
        m1_awvalid = 1'b0;
        m1_wvalid = 1'b0;
        expect_rd(MST_M0, 4'h4, 32'h8000_5000, 8'd0, 64'hE000);
        expect_rd(MST_M1, 4'hB, 32'h8000_6000, 8'd1, 64'hF000);
        fork
            ar_issue(0, 4'h4, 32'h8000_5000, 8'd0);
            ar_issue(1, 4'hB, 32'h8000_6000, 8'd1);
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    check("m1_ar_blocked", 64'(s_arvalid && (s_arid == 4'hB)), 64'd0);
                end
                @(posedge clock); #1;
                s_bvalid = 1'b1;
                s_bid = 4'h2;
                @(negedge clock);
                check("b_pass_valid", 64'(m1_bvalid), 64'd1);
                check("b_pass_ready", 64'(s_bready), 64'd1);
                @(posedge clock); #1;
                s_bvalid = 1'b0;
                n = 0;
                found = 1'b0;
                while (!found && n < 20) begin
                    @(negedge clock);
                    if (s_arvalid && (s_arid == 4'hB)) found = 1'b1;
                    else n++;
                end
                check("m1_ar_after_b_gap", 64'(n), 64'd1);
            end
        join
        wait_idle();

        // Four-beat burst with rlast tied low and a short rready stall.
        expect_rd(MST_M1, 4'hC, 32'h8000_7000, 8'd3, 64'h5000);
        fork
            ar_issue(1, 4'hC, 32'h8000_7000, 8'd3);
            begin
                n = 0;
                found = 1'b0;
                while (!found && n < 100) begin
                    @(negedge clock);
                    found = m1_rvalid & m1_rready;
                    n++;
                end
                @(posedge clock); #1;
                m1_rready = 1'b0;
                @(negedge clock);
                check("s_rready_follows", 64'(s_rready), 64'd0);
                check("m1_rvalid_held", 64'(m1_rvalid), 64'd1);
                @(posedge clock); #1;
                m1_rready = 1'b1;
            end
            begin : last_watch
                int  k;
                logic seen;
                k = 0;
                seen = 1'b0;
                while (!seen && k < 100) begin
                    @(negedge clock);
                    seen = m1_rvalid & m1_rready & m1_rlast;
                    k++;
                end
                check("burst_last_seen", 64'(seen), 64'd1);
                @(posedge clock); #1;
                check("idle_after_last", 64'(dut.r_state), 64'(ST_IDLE));
            end
        join
        wait_idle();

        // Reset in the middle of a burst, then a normal m0 read.
        expect_rd(MST_M0, 4'h5, 32'h8000_8000, 8'd3, 64'h7000);
        ar_issue(0, 4'h5, 32'h8000_8000, 8'd3);
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            @(negedge clock);
            found = m0_rvalid & m0_rready;
            n++;
        end
        check("abort_burst_started", 64'(found), 64'd1);
        #2;
        reset = 1'b0;
        exp_r.delete();
        exp_ar.delete();
        #1;
        check("abort_m0_arready", 64'(m0_arready), 64'd0);
        check("abort_m1_arready", 64'(m1_arready), 64'd0);
        check("abort_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check("abort_m1_rvalid", 64'(m1_rvalid), 64'd0);
        check("abort_s_arvalid", 64'(s_arvalid), 64'd0);
        check("abort_s_rready", 64'(s_rready), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        expect_rd(MST_M0, 4'h6, 32'h8000_9000, 8'd0, 64'hCAFE);
        ar_issue(0, 4'h6, 32'h8000_9000, 8'd0);
        wait_idle();

        check("sb_r_empty", 64'(exp_r.size()), 64'd0);
        check("sb_ar_empty", 64'(exp_ar.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
